// File: rtl/mem_datos_pkg.sv
// ----------------------------------------------------------------------------
// mem_datos_pkg : size/state encodings and lane-mask helpers for mem_datos
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_datos_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Byte-lane enables for a 2^size byte access at byte offset off (up to 8 lanes).
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] m;
    m = ((16'd1 << (4'd1 << size)) - 16'd1) << off;
    return m[7:0];
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    logic [2:0] low;
    low = 3'((4'd1 << size) - 4'd1);
    return (off & low) == 3'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ext.sv
// ----------------------------------------------------------------------------
// mem_ext : load lane select with sign/zero extension
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_ext
  import mem_datos_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OB     = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_size,
  input  logic [OB-1:0]     i_off,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] w_sh;
  logic [DATA_W-1:0] w_keep;
  logic [6:0]        w_nbits;
  logic              w_sign;

  always_comb begin
    w_sh    = i_data >> {i_off, 3'b000};
    w_nbits = 7'd8 << i_size;
    // A shift of DATA_W or more yields 0, so a full-width access keeps every bit.
    w_keep  = (ONE << w_nbits) - ONE;
    w_sign  = 1'b0;
    case (i_size)
      SZ_B:    w_sign = w_sh[7];
      SZ_H:    w_sign = w_sh[15];
      default: w_sign = w_sh[31];
    endcase
    o_data = (w_sh & w_keep) | ({DATA_W{i_signed & w_sign}} & ~w_keep);
  end

endmodule

`default_nettype wire

// File: rtl/mem_datos.sv
// ----------------------------------------------------------------------------
// mem_datos : byte-lane data memory with valid/ready requests and init sweep
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_datos
  import mem_datos_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              reloj,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int NB    = DATA_W/8;
  localparam int OB    = $clog2(NB);
  localparam int RA_W  = $clog2(DEPTH);
  localparam int CLR_W = $clog2(DEPTH+1);
  localparam int IDX_W = ADDR_W - OB;

  state_t             r_state;
  logic [CLR_W-1:0]   r_clr;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_rdata;

  logic               w_acc;
  logic [OB-1:0]      w_off;
  logic [IDX_W-1:0]   w_idx;
  logic               w_err;
  logic [NB-1:0]      w_mask;
  logic [DATA_W-1:0]  w_wsh;
  logic [NB-1:0]      w_we;
  logic [RA_W-1:0]    w_wa;
  logic [DATA_W-1:0]  w_wd;

  assign req_ready = (r_state == ST_RUN);
  assign w_acc     = req_valid & req_ready;
  assign w_off     = req_addr[OB-1:0];
  assign w_idx     = req_addr[ADDR_W-1:OB];
  assign w_err     = !is_aligned(req_size, 3'(w_off))
                   | (32'(w_idx) >= 32'(DEPTH))
                   | ((4'd1 << req_size) > 4'(NB));
  assign w_mask    = NB'(lane_mask(req_size, 3'(w_off)));
  assign w_wsh     = req_wdata << {w_off, 3'b000};

  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
      r_clr   <= '0;
    end else if (r_state == ST_INIT) begin
      if (r_clr == CLR_W'(DEPTH)) r_state <= ST_RUN;
      else                        r_clr   <= r_clr + CLR_W'(1);
    end
  end

  // The clearing sweep owns the write port during INIT; stores own it in RUN.
  always_comb begin
    w_we = '0;
    w_wa = r_clr[RA_W-1:0];
    w_wd = '0;
    if (r_state == ST_INIT) begin
      if (r_clr < CLR_W'(DEPTH)) w_we = '1;
    end else if (w_acc && req_we && !w_err) begin
      w_we = w_mask;
      w_wa = w_idx[RA_W-1:0];
      w_wd = w_wsh;
    end
  end

  always_ff @(posedge reloj) begin
    for (int b = 0; b < NB; b++) begin
      if (w_we[b]) r_mem[w_wa][b*8 +: 8] <= w_wd[b*8 +: 8];
    end
    r_rdata <= r_mem[w_idx[RA_W-1:0]];
  end

  logic          r_a_v, r_a_ld, r_a_err, r_a_sgn;
  logic [1:0]    r_a_size;
  logic [OB-1:0] r_a_off;

  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      r_a_v    <= 1'b0;
      r_a_ld   <= 1'b0;
      r_a_err  <= 1'b0;
      r_a_sgn  <= 1'b0;
      r_a_size <= SZ_B;
      r_a_off  <= '0;
    end else begin
      r_a_v    <= w_acc;
      r_a_ld   <= !req_we && !w_err;
      r_a_err  <= w_err;
      r_a_sgn  <= req_signed;
      r_a_size <= req_size;
      r_a_off  <= w_off;
    end
  end

  logic [DATA_W-1:0] w_ext;

  mem_ext #(
    .DATA_W (DATA_W)
  ) u_ext (
    .i_data   (r_rdata),
    .i_size   (r_a_size),
    .i_off    (r_a_off),
    .i_signed (r_a_sgn),
    .o_data   (w_ext)
  );

  logic              r_b_v, r_b_err;
  logic [DATA_W-1:0] r_b_data;

  always_ff @(posedge reloj) begin
    if (!reset_n) begin
      r_b_v    <= 1'b0;
      r_b_err  <= 1'b0;
      r_b_data <= '0;
    end else begin
      r_b_v    <= r_a_v;
      r_b_err  <= r_a_v && r_a_err;
      r_b_data <= (r_a_v && r_a_ld) ? w_ext : '0;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_c_v, r_c_err;
      logic [DATA_W-1:0] r_c_data;

      always_ff @(posedge reloj) begin
        if (!reset_n) begin
          r_c_v    <= 1'b0;
          r_c_err  <= 1'b0;
          r_c_data <= '0;
        end else begin
          r_c_v    <= r_b_v;
          r_c_err  <= r_b_err;
          r_c_data <= r_b_data;
        end
      end

      assign rsp_valid = r_c_v;
      assign rsp_err   = r_c_err;
      assign rsp_data  = r_c_data;
    end else begin : g_lat1
      assign rsp_valid = r_b_v;
      assign rsp_err   = r_b_err;
      assign rsp_data  = r_b_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mem_datos.sv
// ----------------------------------------------------------------------------
// tb_mem_datos : directed bench driving RD_LAT=1 and RD_LAT=2 copies in parallel
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_datos;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;

  logic        rdy1, v1, e1;
  logic [31:0] d1;
  logic        rdy2, v2, e2;
  logic [31:0] d2;

  int n_cmp = 0;
  int n_err = 0;

  mem_datos #(.DATA_W(32), .DEPTH(128), .ADDR_W(10), .RD_LAT(1)) u_dut1 (
    .reloj      (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (rdy1),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (v1),
    .rsp_data   (d1),
    .rsp_err    (e1)
  );

  mem_datos #(.DATA_W(32), .DEPTH(128), .ADDR_W(10), .RD_LAT(2)) u_dut2 (
    .reloj      (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (rdy2),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (v2),
    .rsp_data   (d2),
    .rsp_err    (e2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [9:0]  a;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        ee;
  } req_t;

  req_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] sz, input logic sg, input logic [9:0] a,
                     input logic [31:0] wd, input logic [31:0] ed, input logic ee);
    req_t r;
    r.we = we; r.sz = sz; r.sg = sg; r.a = a; r.wd = wd; r.ed = ed; r.ee = ee;
    q.push_back(r);
  endtask

  // Issue the queued requests back to back; check latency-1 and latency-2 responses.
  task automatic run(input string tag);
    int n;
    n = q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i < n) begin
        req_valid  = 1'b1;
        req_we     = q[i].we;
        req_size   = q[i].sz;
        req_signed = q[i].sg;
        req_addr   = q[i].a;
        req_wdata  = q[i].wd;
      end else begin
        req_valid  = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i >= 1 && i <= n) begin
        chk($sformatf("%s[%0d].v1", tag, i-1), 32'(v1), 32'd1);
        chk($sformatf("%s[%0d].d1", tag, i-1), d1, q[i-1].ed);
        chk($sformatf("%s[%0d].e1", tag, i-1), 32'(e1), 32'(q[i-1].ee));
      end else begin
        chk($sformatf("%s.idle%0d.v1", tag, i), 32'(v1), 32'd0);
      end
      if (i >= 2) begin
        chk($sformatf("%s[%0d].v2", tag, i-2), 32'(v2), 32'd1);
        chk($sformatf("%s[%0d].d2", tag, i-2), d2, q[i-2].ed);
        chk($sformatf("%s[%0d].e2", tag, i-2), 32'(e2), 32'(q[i-2].ee));
      end else begin
        chk($sformatf("%s.idle%0d.v2", tag, i), 32'(v2), 32'd0);
      end
    end
    q.delete();
  endtask

  // Call with reset_n just raised; the next rising edge is the first sampled high.
  task automatic init_wait(input string tag);
    int cnt;
    cnt = 0;
    @(posedge clk);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (rdy1) break;
      cnt++;
    end
    chk({tag, ".ready_low_cycles"}, 32'(cnt), 32'd128);
    chk({tag, ".ready2"}, 32'(rdy2), 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(rdy1), 32'd0);
    chk("rst.valid", 32'(v1),   32'd0);
    chk("rst.data",  d1,        32'd0);
    chk("rst.err",   32'(e1),   32'd0);
    chk("rst.valid2", 32'(v2),  32'd0);
    chk("rst.data2",  d2,       32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    init_wait("init");

    add(0, 2'b10, 0, 10'h040, 0, 32'h0, 0);
    add(0, 2'b10, 0, 10'h1FC, 0, 32'h0, 0);
    run("cleared");

    add(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0, 0);
    add(0, 2'b10, 0, 10'h010, 0, 32'hDEADBEEF, 0);
    run("word");

    add(1, 2'b01, 0, 10'h022, 32'h00008001, 32'h0, 0);
    add(0, 2'b01, 1, 10'h022, 0, 32'hFFFF8001, 0);
    add(0, 2'b01, 0, 10'h022, 0, 32'h00008001, 0);
    add(0, 2'b10, 0, 10'h020, 0, 32'h80010000, 0);
    run("half");

    add(1, 2'b10, 0, 10'h030, 32'h11223344, 32'h0, 0);
    add(1, 2'b00, 0, 10'h031, 32'h123456AA, 32'h0, 0);
    add(0, 2'b10, 0, 10'h030, 0, 32'h1122AA44, 0);
    add(0, 2'b00, 1, 10'h031, 0, 32'hFFFFFFAA, 0);
    add(0, 2'b00, 0, 10'h033, 0, 32'h00000011, 0);
    run("lanes");

    add(1, 2'b10, 0, 10'h040, 32'hCAFEF00D, 32'h0, 0);
    add(0, 2'b10, 0, 10'h040, 0, 32'hCAFEF00D, 0);
    run("raw");

    add(1, 2'b01, 0, 10'h013, 32'h00005555, 32'h0, 1);
    add(1, 2'b10, 0, 10'h200, 32'h12345678, 32'h0, 1);
    add(1, 2'b11, 0, 10'h010, 32'h77777777, 32'h0, 1);
    add(0, 2'b11, 0, 10'h008, 0, 32'h0, 1);
    add(0, 2'b10, 0, 10'h012, 0, 32'h0, 1);
    add(0, 2'b10, 0, 10'h010, 0, 32'hDEADBEEF, 0);
    add(0, 2'b10, 0, 10'h000, 0, 32'h0, 0);
    run("err");

    add(0, 2'b10, 0, 10'h010, 0, 32'hDEADBEEF, 0);
    add(0, 2'b10, 0, 10'h020, 0, 32'h80010000, 0);
    add(0, 2'b10, 0, 10'h030, 0, 32'h1122AA44, 0);
    add(0, 2'b00, 1, 10'h023, 0, 32'hFFFFFF80, 0);
    run("pipe");

    // Reset with the RD_LAT=2 copy holding two loads in flight.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 10'h010; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 10'h030;
    @(posedge clk);
    #1;
    chk("flush.pre.v1", 32'(v1), 32'd1);
    chk("flush.pre.d1", d1, 32'hDEADBEEF);
    chk("flush.pre.v2", 32'(v2), 32'd0);
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("flush.e1.v1", 32'(v1), 32'd0);
    chk("flush.e1.v2", 32'(v2), 32'd0);
    chk("flush.e1.ready", 32'(rdy1), 32'd0);
    @(posedge clk);
    #1;
    chk("flush.e2.v2", 32'(v2), 32'd0);
    chk("flush.e2.d2", d2, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    init_wait("reinit");

    add(0, 2'b10, 0, 10'h010, 0, 32'h0, 0);
    run("after_reinit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_datos.md
# mem_datos

Parametrised data memory that replaces the fixed 32-bit word/half-word store in the datapath's memory stage. It adds:
- byte, half, word and (for 64-bit builds) double-word access with byte-lane writes;
- sign or zero extension on loads;
- misalignment and range error reporting;
- a valid/ready request channel with a 1- or 2-cycle read pipeline;
- a post-reset clearing sweep.

The load/store unit drives it with one request per cycle and receives exactly one response per accepted request.

## Interface
- DATA_W, 32, word width; only 32 or 64 are legal
- DEPTH, 128, number of words
- ADDR_W, 10, byte-address width; byte offset bits OB = log2(DATA_W/8)
- RD_LAT, 1, response latency in cycles; only 1 or 2 are legal

- reloj  in  1  clock; all state updates on the rising edge
- reset_n  in  1  reset; synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; reset value 0
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = double (legal only when DATA_W = 64)
- req_signed  in  1  sign-extend loads; ignored on stores
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse; reset value 0
- rsp_data  out  DATA_W  load result; 0 for stores and errors; reset value 0
- rsp_err  out  1  error flag for this response; reset value 0

## Operation
- States: INIT, RUN.
  - reset_n = 0 forces INIT, clears the clear-counter and flushes the response pipeline.
  - INIT writes 0 to word k on cycle k, for k = 0..DEPTH-1, then moves to RUN.
  - req_ready = 1 only in RUN.
- Acceptance: a request is accepted on an edge where req_valid and req_ready are both 1. Responses are never back-pressured.
- Decoding:
  - word index = req_addr >> OB
  - byte offset = req_addr[OB-1:0]
  - access bytes = 2^req_size
- Error cases. On error no memory write occurs, and the response has rsp_err = 1 and rsp_data = 0. An access is an error if any of these holds:
  - it is misaligned (offset not a multiple of the access size);
  - the word index is ≥ DEPTH;
  - req_size = 11 while DATA_W = 32.
- Store: only the addressed byte lanes are written, with the low bytes of req_wdata. All other lanes are unchanged. The response carries rsp_err = 0 and rsp_data = 0.
- Load:
  - the addressed lanes are shifted down to bit 0;
  - the upper bits are filled with the sign bit of the access when req_signed = 1, otherwise with 0;
  - a full-width access returns the word unchanged.
- Read-after-write: a load accepted on the edge after a store to the same word returns the new data. There is no same-edge conflict, because only one request is accepted per edge.

## Timing
- A request accepted on edge N has its response (rsp_valid = 1) visible from edge N+RD_LAT until edge N+RD_LAT+1.
- Back-to-back requests give back-to-back responses, in order.
- RD_LAT = 2 adds an output register after the extension logic.
- INIT lasts exactly DEPTH cycles after the edge where reset_n is first sampled high; req_ready rises on the following edge.
- Reset during RUN:
  - in-flight responses are dropped (rsp_valid = 0 from the next edge);
  - no pending store is lost, because stores commit on acceptance;
  - INIT restarts from word 0.
- Reset during INIT restarts the sweep from word 0.

## Structure
- The shared package holds:
  - size encodings SZ_B / SZ_H / SZ_W / SZ_D;
  - the state encoding;
  - a function that returns the byte-lane write mask from size and offset.
- The lane mask / alignment check is shared with the future store buffer.
- One sub-module, mem_ext: a combinational lane-select plus sign/zero extender, parametrised on DATA_W. It is instantiated once, on the read path.
- The array itself is an inferred synchronous RAM with per-byte write enables. Its read port is registered.

## Test plan
- Reset and init:
  - stimulus: reset_n low 2 cycles, then high;
  - response: req_ready stays 0 for exactly DEPTH = 128 cycles, then goes to 1; a word load of any address returns 0x00000000.
- Word round-trip:
  - stimulus: store word 0xDEADBEEF at address 0x10, then load word at 0x10;
  - response: rsp_data = 0xDEADBEEF one cycle after the load is accepted (RD_LAT = 1), rsp_err = 0.
- Half signed/unsigned:
  - stimulus: store half 0x8001 at 0x22, then load signed half at 0x22, then load unsigned half at 0x22;
  - response: signed load gives 0xFFFF8001, unsigned load gives 0x00008001, and a word load at 0x20 gives 0x80010000.
- Byte lanes:
  - stimulus: word 0x11223344 at 0x30, then store byte 0xAA at 0x31;
  - response: a word load at 0x30 gives 0x1122AA44.
- Errors:
  - stimulus: store half at 0x13; store word at byte address 512 (word index 128, out of range with DEPTH = 128 and ADDR_W = 10); double access with DATA_W = 32;
  - response: each gives rsp_err = 1 and rsp_data = 0; memory is unchanged.
- Pipeline and reset:
  - stimulus: RD_LAT = 2, four back-to-back loads; then assert reset_n = 0 while two loads are in flight;
  - response: the four loads return in order on consecutive cycles starting 2 cycles after the first acceptance; the in-flight loads produce no rsp_valid pulse, and INIT restarts.
